// File: rtl/gauss_pkg.sv
// Shared types and frame geometry for the Gaussian filter video path.
package gauss_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int PIXEL_SIZE = 8;
  localparam int MEM_SIZE   = 307200;
  localparam int ADDR_W     = 19;
  localparam int X_W        = $clog2(H_ACTIVE);
  localparam int Y_W        = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_WAIT_SOF,
    CAP_CAPTURE,
    CAP_DONE
  } cap_state_e;

  typedef struct packed {
    logic [PIXEL_SIZE-1:0] r;
    logic [PIXEL_SIZE-1:0] g;
    logic [PIXEL_SIZE-1:0] b;
  } pixel_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x, y, linear address and line base, advanced by
// adders only. Priority: clear, origin, next line, step.
module raster_counter
  import gauss_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              origin_i,
  input  logic              next_line_i,
  input  logic              step_i,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    base_d = base_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
      base_d = '0;
    end else if (origin_i) begin
      // The sof pixel itself lands at 0, so the counter resumes at position 1.
      x_d    = X_W'(1);
      y_d    = '0;
      addr_d = ADDR_W'(1);
      base_d = '0;
    end else if (next_line_i) begin
      x_d    = '0;
      y_d    = y_q + Y_W'(1);
      base_d = base_q + LINE_STEP;
      addr_d = base_q + LINE_STEP;
    end else if (step_i) begin
      x_d    = x_q + X_W'(1);
      addr_d = addr_q + ADDR_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
      base_q <= base_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/frame_capture.sv
// Sink-side frame writer: checks sof/eol raster framing on the filtered RGB
// stream and writes each pixel to the frame buffer at y*H_ACTIVE + x.
module frame_capture
  import gauss_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic                    in_eol,
  input  logic [PIXEL_SIZE-1:0]   in_r,
  input  logic [PIXEL_SIZE-1:0]   in_g,
  input  logic [PIXEL_SIZE-1:0]   in_b,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [3*PIXEL_SIZE-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err_sof,
  output logic                    err_eol
);

  cap_state_e        state_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  pixel_t            wr_data_q;
  logic              err_sof_q, err_eol_q;

  logic [X_W-1:0]    cnt_x;
  logic [Y_W-1:0]    cnt_y;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_clear, cnt_origin, cnt_next, cnt_step;

  logic   accept, at_line_end, last_line, line_done, frame_end;
  pixel_t pix_in;

  assign pix_in      = {in_r, in_g, in_b};
  assign in_ready    = (state_q == CAP_WAIT_SOF) || (state_q == CAP_CAPTURE);
  assign accept      = in_valid && in_ready;
  assign at_line_end = (cnt_x == X_W'(H_ACTIVE - 1));
  assign last_line   = (cnt_y == Y_W'(V_ACTIVE - 1));
  assign line_done   = in_eol || at_line_end;
  // Early eol on the last line ends the frame just like the final pixel does.
  assign frame_end   = (state_q == CAP_CAPTURE) && accept && !in_sof && last_line && line_done;

  always_comb begin
    cnt_clear  = 1'b0;
    cnt_origin = 1'b0;
    cnt_next   = 1'b0;
    cnt_step   = 1'b0;
    case (state_q)
      CAP_IDLE:     cnt_clear  = start;
      CAP_WAIT_SOF: cnt_origin = accept && in_sof;
      CAP_CAPTURE: begin
        if (accept) begin
          if (in_sof)         cnt_origin = 1'b1;
          else if (frame_end) cnt_clear  = 1'b1;
          else if (line_done) cnt_next   = 1'b1;
          else                cnt_step   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  raster_counter u_raster (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .origin_i    (cnt_origin),
    .next_line_i (cnt_next),
    .step_i      (cnt_step),
    .x_o         (cnt_x),
    .y_o         (cnt_y),
    .addr_o      (cnt_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= CAP_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        CAP_IDLE: begin
          if (start) begin
            state_q   <= CAP_WAIT_SOF;
            err_sof_q <= 1'b0;
            err_eol_q <= 1'b0;
          end
        end
        CAP_WAIT_SOF: begin
          if (accept && in_sof) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= pix_in;
            state_q   <= CAP_CAPTURE;
          end
        end
        CAP_CAPTURE: begin
          if (accept) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= pix_in;
            if (in_sof) begin
              wr_addr_q <= '0;
              if (cnt_addr != '0) err_sof_q <= 1'b1;
            end else begin
              wr_addr_q <= cnt_addr;
              // Flags both an early eol and a missing eol at the line end.
              if (in_eol != at_line_end) err_eol_q <= 1'b1;
              if (frame_end) state_q <= CAP_DONE;
            end
          end
        end
        default: state_q <= CAP_IDLE;
      endcase
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = in_ready;
  assign done    = (state_q == CAP_DONE);
  assign err_sof = err_sof_q;
  assign err_eol = err_eol_q;

endmodule

// File: tb/tb_frame_capture.sv
// Scoreboard bench for frame_capture: a raster model predicts every write and
// status flag; writes are popped and compared as the DUT produces them.
module tb_frame_capture;
  import gauss_pkg::*;

  logic                    clock, reset, start, in_valid, in_ready, in_sof, in_eol;
  logic [PIXEL_SIZE-1:0]   in_r, in_g, in_b;
  logic                    wr_en, busy, done, err_sof, err_eol;
  logic [ADDR_W-1:0]       wr_addr;
  logic [3*PIXEL_SIZE-1:0] wr_data;

  frame_capture dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sof  (in_sof),
    .in_eol  (in_eol),
    .in_r    (in_r),
    .in_g    (in_g),
    .in_b    (in_b),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err_sof (err_sof),
    .err_eol (err_eol)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          addr;
    logic [23:0] data;
    bit          done;
  } exp_t;

  typedef enum {M_IDLE, M_WAIT, M_CAP, M_DONE} mstate_e;

  exp_t    exp_q[$];
  exp_t    mon_e;
  int      n_cmp = 0;
  int      n_bad = 0;
  int      last_wr_addr = -1;
  int      done_cnt = 0;
  bit      mon_en = 1'b0;
  bit      gaps = 1'b0;
  mstate_e m_st = M_IDLE;
  int      m_x = 0;
  int      m_y = 0;
  bit      m_esof = 1'b0;
  bit      m_eeol = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (m_st == M_WAIT) || (m_st == M_CAP);
  endfunction

  // Reference behaviour of one clock edge, expressed in raster coordinates.
  task automatic model(input bit st, input bit v, input bit sof, input bit eol, input logic [23:0] pix);
    bit acc;
    int a;
    acc = v && m_ready();
    a   = m_y * H_ACTIVE + m_x;
    case (m_st)
      M_IDLE: if (st) begin
        m_st = M_WAIT; m_esof = 1'b0; m_eeol = 1'b0; m_x = 0; m_y = 0;
      end
      M_WAIT: if (acc && sof) begin
        exp_q.push_back('{0, pix, 1'b0});
        m_x = 1; m_y = 0; m_st = M_CAP;
      end
      M_CAP: if (acc) begin
        if (sof) begin
          if (a != 0) m_esof = 1'b1;
          exp_q.push_back('{0, pix, 1'b0});
          m_x = 1; m_y = 0;
        end else begin
          if (eol != (m_x == H_ACTIVE - 1)) m_eeol = 1'b1;
          if (eol || m_x == H_ACTIVE - 1) begin
            if (m_y == V_ACTIVE - 1) begin
              exp_q.push_back('{a, pix, 1'b1});
              m_st = M_DONE;
            end else begin
              exp_q.push_back('{a, pix, 1'b0});
              m_x = 0; m_y++;
            end
          end else begin
            exp_q.push_back('{a, pix, 1'b0});
            m_x++;
          end
        end
      end
      default: m_st = M_IDLE;
    endcase
  endtask

  // Every write the DUT issues must be the one the model queued for this edge.
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      check("wr_en", 32'(wr_en), 32'(exp_q.size() != 0));
      if (wr_en === 1'b1) last_wr_addr = int'(wr_addr);
      if (done === 1'b1) done_cnt++;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (wr_en === 1'b1) begin
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
        end
        check("done", 32'(done), 32'(mon_e.done));
      end else begin
        check("done_idle", 32'(done), 32'd0);
      end
    end
  end

  task automatic cycle(input bit st, input bit v, input bit sof, input bit eol, input logic [23:0] pix);
    @(negedge clock);
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("busy", 32'(busy), 32'(m_ready()));
    check("err_sof", 32'(err_sof), 32'(m_esof));
    check("err_eol", 32'(err_eol), 32'(m_eeol));
    start = st; in_valid = v; in_sof = sof; in_eol = eol;
    {in_r, in_g, in_b} = pix;
    model(st, v, sof, eol, pix);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic beat(input bit sof, input bit eol, input logic [23:0] pix);
    if (gaps && $urandom_range(0, 3) == 0) idle();
    cycle(1'b0, 1'b1, sof, eol, pix);
  endtask

  // Well-formed beats continuing from the model's current position.
  task automatic clean_beats(input int n);
    int a;
    logic [7:0] lo;
    for (int i = 0; i < n; i++) begin
      a  = (m_st == M_WAIT) ? 0 : m_y * H_ACTIVE + m_x;
      lo = a[7:0];
      beat(m_st == M_WAIT, (m_st == M_CAP) && (m_x == H_ACTIVE - 1), {lo, lo, lo});
    end
  endtask

  task automatic do_reset(input bit st);
    @(negedge clock);
    reset = 1'b1; start = st; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    m_st = M_IDLE; m_esof = 1'b0; m_eeol = 1'b0; m_x = 0; m_y = 0;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;

    // Reset with start held: reset must win, outputs at reset values.
    do_reset(1'b1);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    mon_en = 1'b1;
    idle();
    idle();

    // Pre-sof garbage is discarded, then the sof beat is written at 0.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    for (int i = 0; i < 5; i++) beat(1'b0, 1'(i == 2), 24'($urandom));
    check("no_garbage_write", 32'(last_wr_addr), 32'hffff_ffff);
    clean_beats(1);
    idle();
    check("first_addr", 32'(last_wr_addr), 32'd0);

    // Clean capture up to address 1000, then reset mid-frame.
    clean_beats(999);
    idle();
    check("clean_last", 32'(last_wr_addr), 32'd999);
    check("clean_err_eol", 32'(err_eol), 32'd0);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) idle();

    // Errored frame with random gaps.
    gaps = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    clean_beats(100);
    beat(1'b0, 1'b1, 24'h12_34_56);
    idle();
    check("early_eol_flag", 32'(err_eol), 32'd1);
    clean_beats(1);
    idle();
    check("after_early_eol", 32'(last_wr_addr), 32'd640);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    clean_beats(639 + 639);
    beat(1'b0, 1'b0, 24'hab_cd_ef);
    clean_beats(1);
    idle();
    check("missing_eol_wrap", 32'(last_wr_addr), 32'd1920);
    clean_beats(5000 - 1921);
    beat(1'b1, 1'b0, 24'h5a_5a_5a);
    idle();
    check("mid_sof_addr", 32'(last_wr_addr), 32'd0);
    check("mid_sof_flag", 32'(err_sof), 32'd1);

    // Finish quickly: one-pixel lines via early eol, then a full last line.
    for (int i = 0; i < V_ACTIVE - 1; i++) beat(1'b0, 1'b1, 24'($urandom));
    clean_beats(H_ACTIVE);
    idle();
    check("last_pixel_done", 32'(done), 32'd1);
    check("last_pixel_addr", 32'(last_wr_addr), 32'(MEM_SIZE - 1));
    idle();
    idle();

    // Early eol on the last line also ends the frame; start clears errors.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    clean_beats(1);
    for (int i = 0; i < V_ACTIVE - 1; i++) beat(1'b0, 1'b1, 24'($urandom));
    clean_beats(5);
    beat(1'b0, 1'b1, 24'h77_66_55);
    idle();
    check("early_last_done", 32'(done), 32'd1);
    check("early_last_addr", 32'(last_wr_addr), 32'((V_ACTIVE - 1) * H_ACTIVE + 5));
    for (int i = 0; i < 4; i++) idle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
# frame_capture

Sink-side frame writer for the Gaussian filter video path. It accepts the filter's output RGB pixel stream, checks raster framing (start-of-frame, end-of-line), and writes each pixel into a 640x480 frame buffer at its raster address. It is the consumer counterpart of the frame-memory pixel source that feeds the filter. Benches and the display path read the captured frame back.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- PIXEL_SIZE, 8, bits per colour channel
- ADDR_W, 19, frame-buffer address width (covers 307200 entries)

- clock  in  1  system clock, rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  arm capture of the next frame; ignored unless IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts the beat this cycle
- in_sof  in  1  beat is first pixel of a frame
- in_eol  in  1  beat is last pixel of a line
- in_r, in_g, in_b  in  PIXEL_SIZE each  pixel channels
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address, y*H_ACTIVE + x
- wr_data  out  3*PIXEL_SIZE  {r,g,b}
- busy  out  1  high in WAIT_SOF or CAPTURE
- done  out  1  one-cycle pulse after the last pixel is written
- err_sof  out  1  sticky: sof seen mid-frame
- err_eol  out  1  sticky: eol position mismatch

## Operation
- Beat accepted when in_valid && in_ready.
- States: IDLE -> (start) WAIT_SOF -> (accepted sof beat) CAPTURE -> (last pixel accepted) DONE -> IDLE.
- In IDLE, in_ready=0. The start pulse clears err_sof and err_eol.
- In WAIT_SOF, in_ready=1. Non-sof beats are discarded with no write. A sof beat is written to addr 0, then x=1, y=0, and the state moves to CAPTURE.
- In CAPTURE, in_ready=1. Each accepted beat is written at the running address (x, y, and address counters; no multiplier).
- End of line: the expected end is x==H_ACTIVE-1.
  - in_eol with x≠H_ACTIVE-1: set err_eol, write the pixel, then jump to x=0, y+1, addr=(y+1)*H_ACTIVE. The line-base register holds this value.
  - x==H_ACTIVE-1 with in_eol=0: set err_eol and wrap to the next line anyway.
- sof in CAPTURE at addr≠0: set err_sof, write the pixel at addr 0, then x=1, y=0 (resync).
- The pixel accepted at x=H_ACTIVE-1, y=V_ACTIVE-1 is the last pixel. It is written, and the state moves to DONE, regardless of in_eol.
- DONE lasts one cycle: in_ready=0, done=1. Then IDLE.
- An early eol on the last line that yields y==V_ACTIVE also ends the frame (DONE).
- Address never exceeds H_ACTIVE*V_ACTIVE-1.

## Timing
- Reset values: state IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err_sof=0, err_eol=0.
- in_ready is decoded from the state register only; it has no combinational path from inputs.
- Write latency is 1 cycle. wr_en, wr_addr, and wr_data are registered in the cycle after acceptance.
- done asserts in the cycle after the last pixel is accepted, coincident with its wr_en.
- Throughput is one pixel per clock with no bubbles. A full frame takes 307200 accepted beats plus the DONE cycle.
- Reset mid-frame returns to IDLE next edge. No further wr_en is issued, and counters and errors clear.
- start in the same cycle as reset: reset wins.
- Error flags set in the cycle after the offending beat and hold until the next start or reset.

## Structure
- Shared package gauss_pkg holds:
  - H_ACTIVE, V_ACTIVE, PIXEL_SIZE, MEM_SIZE=307200
  - the capture state enum
  - the {r,g,b} pixel struct (shared with the filter and source)
- One sub-module, raster_counter: x/y/address/line-base counters with wrap, jump-to-next-line, and reset-to-origin controls. The FSM stays in frame_capture.

## Test plan
- Clean frame: start, then 307200 valid beats with sof on the first, eol every 640th, and data = addr[7:0] per channel. Expect:
  - wr_addr 0..307199 in order, with matching data
  - done one cycle after the last accept
  - no errors set
- Pre-sof garbage: 5 beats with sof=0 after start, then a clean frame. Expect no writes for the first 5 beats and first wr_addr=0 on the sof beat.
- Early eol: eol on x=100 of line 0. Expect:
  - err_eol=1
  - next beat written at addr 640
  - frame completes and done pulses
- Missing eol and mid-frame sof:
  - No eol at x=639 on line 2: expect err_eol and a wrap to addr 1920.
  - Later, sof at addr 5000: expect err_sof and that pixel written at addr 0.
- Backpressure and gaps: in_valid toggled randomly. Expect addresses contiguous, in_ready=1 throughout CAPTURE, and in_ready=0 in DONE/IDLE.
- Reset at addr 1000: expect wr_en=0 from the next cycle, busy=0, and a subsequent start capturing a full frame from addr 0.
